// File: rtl/read_multi_pkg.sv
// Shared types and constants for the read_multi operand/memory read stage.
package read_multi_pkg;
  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 16;
  localparam int unsigned CNVZ_W   = 4;
  localparam int unsigned PC_IDX   = NREG_DEF - 1;

  typedef logic [XLEN_DEF-1:0]         regval_t;
  typedef regval_t [NREG_DEF-1:0]      regfile_t;
  typedef logic [$clog2(NREG_DEF)-1:0] regidx_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_CAPTURED = 2'd2
  } read_state_t;
endpackage

// File: rtl/read_multi_operand_forward.sv
// operand_forward: selects one register (index NREG-1 reads the PC) and applies
// priority forwarding where the lowest-index matching port wins.
module operand_forward
  import read_multi_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 16,
  parameter int unsigned NFWD = 2,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic [NREG*XLEN-1:0] i_registers,
  input  logic [XLEN-1:0]      i_pc,
  input  logic [RW-1:0]        i_src,
  input  logic [NFWD-1:0]      i_fwd_valid,
  input  logic [NFWD*RW-1:0]   i_fwd_reg,
  input  logic [NFWD*XLEN-1:0] i_fwd_value,
  output logic [XLEN-1:0]      o_value
);
  logic w_hit;

  always_comb begin
    o_value = i_registers[i_src*XLEN +: XLEN];
    if (i_src == RW'(NREG - 1)) o_value = i_pc;
    w_hit = 1'b0;
    for (int unsigned j = 0; j < NFWD; j++) begin
      if (!w_hit && i_fwd_valid[j] && (i_fwd_reg[j*RW +: RW] == i_src)) begin
        o_value = i_fwd_value[j*XLEN +: XLEN];
        w_hit   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/read_multi.sv
// read_multi: operand resolve with forwarding, CNVZ predicate, and one outstanding
// memory read with capture buffer and timeout. Optional store snoop: READ_STORE_FORWARD_EN.
module read_multi
  import read_multi_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREG         = 16,
  parameter int unsigned NSRC         = 3,
  parameter int unsigned NFWD         = 2,
  parameter int unsigned MEM_WAIT_MAX = 255,
  localparam int unsigned RW          = $clog2(NREG)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREG*XLEN-1:0] registers,
  input  logic [CNVZ_W-1:0]    flags,
  input  logic                 in_valid,
  output logic                 in_hold,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [7:0]           in_operation,
  input  logic [NSRC*RW-1:0]   in_src_reg,
  input  logic [XLEN-1:0]      in_adjustment,
  input  logic                 in_is_reading_memory,
  input  logic [CNVZ_W-1:0]    in_cnvz_mask,
  input  logic                 in_is_non_zero_active,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RW-1:0]   fwd_reg,
  input  logic [NFWD*XLEN-1:0] fwd_value,
  output logic                 mem_address_enable,
  output logic [XLEN-1:0]      mem_address,
  input  logic                 mem_data_valid,
  input  logic [XLEN-1:0]      mem_data,
  input  logic                 out_hold,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_pc,
  output logic [7:0]           out_operation,
  output logic [NSRC*XLEN-1:0] out_src_value,
`ifdef READ_STORE_FORWARD_EN
  input  logic                 st_valid,
  input  logic [XLEN-1:0]      st_address,
  input  logic [XLEN-1:0]      st_data,
`endif
  output logic                 out_mem_fault
);
  localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 1);

  read_state_t          r_state;
  logic [CW-1:0]        r_cnt;
  logic [XLEN-1:0]      r_cap;
  logic                 r_valid;
  logic                 r_fault;
  logic [XLEN-1:0]      r_pc;
  logic [7:0]           r_op;
  logic [NSRC*XLEN-1:0] r_src;

  logic [NSRC*XLEN-1:0] w_src;
  logic [NSRC*XLEN-1:0] w_ld_src;
  logic [XLEN-1:0]      w_addr;
  logic [XLEN-1:0]      w_op0;
  logic                 w_active;
  logic                 w_st_hit;
  logic                 w_mem_rd;
  logic                 w_timeout;
  logic                 w_load;
  logic                 w_ld_valid;
  logic                 w_ld_fault;

  for (genvar g = 0; g < NSRC; g++) begin : g_opnd
    operand_forward #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD)) u_opnd (
      .i_registers (registers),
      .i_pc        (in_pc),
      .i_src       (in_src_reg[g*RW +: RW]),
      .i_fwd_valid (fwd_valid),
      .i_fwd_reg   (fwd_reg),
      .i_fwd_value (fwd_value),
      .o_value     (w_src[g*XLEN +: XLEN])
    );
  end

  assign w_active = in_valid && (in_is_non_zero_active == |(in_cnvz_mask & flags));
  assign w_addr   = w_src[XLEN-1:0] + in_adjustment;

`ifdef READ_STORE_FORWARD_EN
  assign w_st_hit = in_is_reading_memory && st_valid && (st_address == w_addr);
`else
  assign w_st_hit = 1'b0;
`endif

  assign w_mem_rd  = w_active && in_is_reading_memory && !w_st_hit;
  assign w_timeout = (r_cnt == CW'(MEM_WAIT_MAX));

  assign mem_address        = w_addr;
  assign mem_address_enable = !reset && w_mem_rd && (r_state != ST_CAPTURED);
  assign in_hold            = !reset && in_valid &&
                              (out_hold || (r_state != ST_IDLE) || (w_mem_rd && !mem_data_valid));

  // Output-load decision and operand-0 source per state; the FSM below only tracks state.
  always_comb begin
    w_op0 = in_is_reading_memory ? mem_data : w_src[XLEN-1:0];
`ifdef READ_STORE_FORWARD_EN
    if (w_st_hit) w_op0 = st_data;
`endif
    w_load     = 1'b0;
    w_ld_valid = 1'b1;
    w_ld_fault = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_load     = !out_hold && !(w_mem_rd && !mem_data_valid);
        w_ld_valid = w_active;
      end
      ST_WAIT: begin
        w_load     = !out_hold && (mem_data_valid || w_timeout);
        w_ld_fault = !mem_data_valid;
        w_op0      = mem_data_valid ? mem_data : '0;
      end
      ST_CAPTURED: begin
        w_load = !out_hold;
        w_op0  = r_cap;
      end
      default: ;
    endcase
    w_ld_src            = w_src;
    w_ld_src[XLEN-1:0]  = w_op0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_pc    <= '0;
      r_op    <= '0;
      r_src   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_ld_valid;
        r_fault <= w_ld_valid && w_ld_fault;
        if (w_ld_valid) begin
          r_pc  <= in_pc;
          r_op  <= in_operation;
          r_src <= w_ld_src;
        end
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_mem_rd && !mem_data_valid) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_data_valid) begin
            if (out_hold) begin
              r_state <= ST_CAPTURED;
              r_cap   <= mem_data;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_timeout) begin
            if (!out_hold) r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CAPTURED: if (!out_hold) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid     = r_valid;
  assign out_mem_fault = r_fault;
  assign out_pc        = r_pc;
  assign out_operation = r_op;
  assign out_src_value = r_src;
endmodule
